// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream style payload/handshake bundle between the packet generator and its sink.
interface axis_pkt_gen_if #(
  parameter int unsigned DSIZE = 8
);
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tvalid;
  logic             axis_tready;
  logic             axis_tlast;

  modport master (
    output axis_tdata,
    output axis_tvalid,
    output axis_tlast,
    input  axis_tready
  );

  modport slave (
    input  axis_tdata,
    input  axis_tvalid,
    input  axis_tlast,
    output axis_tready
  );
endinterface

// File: rtl/axis_pkt_gen.sv
// Packet generator: emits counting-pattern packets of pkt_len beats, optionally
// separated by gap_len idle cycles. Build macro AXIS_PKT_GEN_GAP_EN enables the
// inter-packet GAP state; without it gap_len is ignored and packets run back-to-back.
module axis_pkt_gen #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LSIZE = 10,
  parameter int unsigned GSIZE = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LSIZE-1:0]  pkt_len,
  input  logic [GSIZE-1:0]  gap_len,
  axis_pkt_gen_if.master    axis,
  output logic [15:0]       pkt_cnt,
  output logic              busy
);

  localparam int unsigned CSIZE = 16;

`ifdef AXIS_PKT_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [LSIZE-1:0] beat_q, beat_d;
  logic [LSIZE-1:0] last_q, last_d;
  logic [CSIZE-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [DSIZE-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             busy_q, busy_d;
  logic             start;

`ifdef AXIS_PKT_GEN_GAP_EN
  logic [GSIZE-1:0] gap_q, gap_d;
  logic [GSIZE-1:0] gap_cnt_q, gap_cnt_d;
`else
  logic unused_gap_len;
  assign unused_gap_len = ^gap_len;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d    = last_q;
    pkt_cnt_d = pkt_cnt_q;
    start     = 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      SEND: begin
        if (tvalid_q && axis.axis_tready) begin
          if (tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CSIZE'(1);
`ifdef AXIS_PKT_GEN_GAP_EN
            if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q - GSIZE'(1);
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
`else
            if (enable) start = 1'b1;
            else        state_d = IDLE;
`endif
          end else begin
            beat_d = beat_q + LSIZE'(1);
          end
        end
      end
`ifdef AXIS_PKT_GEN_GAP_EN
      GAP: begin
        if (gap_cnt_q == '0) begin
          if (enable) start = 1'b1;
          else        state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GSIZE'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Latch point: capture length (0 treated as 1) and gap for the new packet
    if (start) begin
      state_d = SEND;
      beat_d  = '0;
      last_d  = (pkt_len == '0) ? '0 : pkt_len - LSIZE'(1);
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_d   = gap_len;
`endif
    end

    tvalid_d = (state_d == SEND);
    tdata_d  = tvalid_d ? DSIZE'(beat_d) : '0;
    tlast_d  = tvalid_d && (beat_d == last_d);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously so reset aborts a packet at once
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      last_q    <= '0;
      pkt_cnt_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign axis.axis_tdata  = tdata_q;
  assign axis.axis_tvalid = tvalid_q;
  assign axis.axis_tlast  = tlast_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed testbench for axis_pkt_gen; expected values are hand-derived per scenario.
module tb_axis_pkt_gen;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned LSIZE = 10;
  localparam int unsigned GSIZE = 8;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [LSIZE-1:0] pkt_len;
  logic [GSIZE-1:0] gap_len;
  logic [15:0]      pkt_cnt;
  logic             busy;

  int          vec_cnt  = 0;
  int          err_cnt  = 0;
  logic [15:0] exp_cnt  = 16'd0;

  axis_pkt_gen_if #(.DSIZE(DSIZE)) axis_if ();

  axis_pkt_gen #(.DSIZE(DSIZE), .LSIZE(LSIZE), .GSIZE(GSIZE)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .enable  (enable),
    .pkt_len (pkt_len),
    .gap_len (gap_len),
    .axis    (axis_if.master),
    .pkt_cnt (pkt_cnt),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // Advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pkt_len = '0; gap_len = '0; axis_if.axis_tready = 1'b1;
    step(); step();
    vec_cnt++; if (axis_if.axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_tvalid got %b want 0", axis_if.axis_tvalid); end
    vec_cnt++; if (axis_if.axis_tlast !== 1'b0) begin err_cnt++; $display("FAIL rst_tlast got %b want 0", axis_if.axis_tlast); end
    vec_cnt++; if (axis_if.axis_tdata !== 8'h00) begin err_cnt++; $display("FAIL rst_tdata got %0h want 0", axis_if.axis_tdata); end
    vec_cnt++; if (pkt_cnt !== 16'h0000) begin err_cnt++; $display("FAIL rst_pkt_cnt got %0h want 0", pkt_cnt); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    step(); step();
    vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL idle_no_enable tvalid=%b busy=%b want 0 0", axis_if.axis_tvalid, busy); end
  endtask

  task automatic test_back_to_back();
    pkt_len = 10'd4; gap_len = 8'd0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL b2b_tvalid beat %0d got %b want 1", i, axis_if.axis_tvalid); end
      vec_cnt++; if (axis_if.axis_tdata !== 8'(i % 4)) begin err_cnt++; $display("FAIL b2b_tdata beat %0d got %0d want %0d", i, axis_if.axis_tdata, i % 4); end
      vec_cnt++; if (axis_if.axis_tlast !== ((i % 4) == 3)) begin err_cnt++; $display("FAIL b2b_tlast beat %0d got %b want %b", i, axis_if.axis_tlast, ((i % 4) == 3)); end
      vec_cnt++; if (pkt_cnt !== exp_cnt + 16'(i / 4)) begin err_cnt++; $display("FAIL b2b_pkt_cnt beat %0d got %0d want %0d", i, pkt_cnt, exp_cnt + 16'(i / 4)); end
      if (i == 4) enable = 1'b0;
    end
    exp_cnt = exp_cnt + 16'd2;
    step();
    vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_end_idle tvalid=%b busy=%b want 0 0", axis_if.axis_tvalid, busy); end
    vec_cnt++; if (pkt_cnt !== exp_cnt) begin err_cnt++; $display("FAIL b2b_end_cnt got %0d want %0d", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    pkt_len = 10'd3; enable = 1'b1; axis_if.axis_tready = 1'b1;
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd0 || axis_if.axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL stall_beat0 tdata=%0d tvalid=%b want 0 1", axis_if.axis_tdata, axis_if.axis_tvalid); end
    enable = 1'b0;
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd1) begin err_cnt++; $display("FAIL stall_beat1 tdata got %0d want 1", axis_if.axis_tdata); end
    axis_if.axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tdata !== 8'd1 || axis_if.axis_tvalid !== 1'b1 || axis_if.axis_tlast !== 1'b0) begin
        err_cnt++; $display("FAIL stall_hold cyc %0d tdata=%0d tvalid=%b tlast=%b want 1 1 0", i, axis_if.axis_tdata, axis_if.axis_tvalid, axis_if.axis_tlast);
      end
    end
    axis_if.axis_tready = 1'b1;
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd2 || axis_if.axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL stall_last tdata=%0d tlast=%b want 2 1", axis_if.axis_tdata, axis_if.axis_tlast); end
    vec_cnt++; if (pkt_cnt !== exp_cnt) begin err_cnt++; $display("FAIL stall_cnt_before got %0d want %0d", pkt_cnt, exp_cnt); end
    exp_cnt = exp_cnt + 16'd1;
    step();
    vec_cnt++; if (pkt_cnt !== exp_cnt || busy !== 1'b0) begin err_cnt++; $display("FAIL stall_done cnt=%0d busy=%b want %0d 0", pkt_cnt, busy, exp_cnt); end
  endtask

  task automatic test_single_beat();
    pkt_len = 10'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tdata !== 8'd0 || axis_if.axis_tlast !== 1'b1 || axis_if.axis_tvalid !== 1'b1) begin
        err_cnt++; $display("FAIL single_beat %0d tdata=%0d tlast=%b tvalid=%b want 0 1 1", i, axis_if.axis_tdata, axis_if.axis_tlast, axis_if.axis_tvalid);
      end
      vec_cnt++; if (pkt_cnt !== exp_cnt + 16'(i)) begin err_cnt++; $display("FAIL single_cnt %0d got %0d want %0d", i, pkt_cnt, exp_cnt + 16'(i)); end
      if (i == 2) enable = 1'b0;
    end
    exp_cnt = exp_cnt + 16'd3;
    step();
    vec_cnt++; if (pkt_cnt !== exp_cnt || axis_if.axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL single_end cnt=%0d tvalid=%b want %0d 0", pkt_cnt, axis_if.axis_tvalid, exp_cnt); end
  endtask

  task automatic test_gap();
    pkt_len = 10'd2; gap_len = 8'd3; enable = 1'b1;
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd0 || axis_if.axis_tlast !== 1'b0) begin err_cnt++; $display("FAIL gap_p1b0 tdata=%0d tlast=%b want 0 0", axis_if.axis_tdata, axis_if.axis_tlast); end
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd1 || axis_if.axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL gap_p1b1 tdata=%0d tlast=%b want 1 1", axis_if.axis_tdata, axis_if.axis_tlast); end
`ifdef AXIS_PKT_GEN_GAP_EN
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || busy !== 1'b1 || axis_if.axis_tdata !== 8'd0) begin
        err_cnt++; $display("FAIL gap_idle %0d tvalid=%b busy=%b tdata=%0d want 0 1 0", i, axis_if.axis_tvalid, busy, axis_if.axis_tdata);
      end
    end
`endif
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd0 || axis_if.axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL gap_p2b0 tdata=%0d tvalid=%b want 0 1", axis_if.axis_tdata, axis_if.axis_tvalid); end
    vec_cnt++; if (pkt_cnt !== exp_cnt + 16'd1) begin err_cnt++; $display("FAIL gap_cnt got %0d want %0d", pkt_cnt, exp_cnt + 16'd1); end
    enable = 1'b0;
    step();
    vec_cnt++; if (axis_if.axis_tdata !== 8'd1 || axis_if.axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL gap_p2b1 tdata=%0d tlast=%b want 1 1", axis_if.axis_tdata, axis_if.axis_tlast); end
`ifdef AXIS_PKT_GEN_GAP_EN
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL gap_tail %0d tvalid=%b busy=%b want 0 1", i, axis_if.axis_tvalid, busy); end
    end
`endif
    exp_cnt = exp_cnt + 16'd2;
    step();
    vec_cnt++; if (busy !== 1'b0 || pkt_cnt !== exp_cnt) begin err_cnt++; $display("FAIL gap_end busy=%b cnt=%0d want 0 %0d", busy, pkt_cnt, exp_cnt); end
    gap_len = 8'd0;
  endtask

  task automatic test_enable_drop_reset();
    pkt_len = 10'd8; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tdata !== 8'(i) || axis_if.axis_tvalid !== 1'b1 || axis_if.axis_tlast !== (i == 7)) begin
        err_cnt++; $display("FAIL drop_beat %0d tdata=%0d tvalid=%b tlast=%b want %0d 1 %b", i, axis_if.axis_tdata, axis_if.axis_tvalid, axis_if.axis_tlast, i, (i == 7));
      end
      if (i == 1) pkt_len = 10'd2;
      if (i == 2) enable = 1'b0;
      if (i == 6) pkt_len = 10'd8;
    end
    exp_cnt = exp_cnt + 16'd1;
    step();
    vec_cnt++; if (busy !== 1'b0 || axis_if.axis_tvalid !== 1'b0 || pkt_cnt !== exp_cnt) begin
      err_cnt++; $display("FAIL drop_idle busy=%b tvalid=%b cnt=%0d want 0 0 %0d", busy, axis_if.axis_tvalid, pkt_cnt, exp_cnt);
    end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vec_cnt++; if (axis_if.axis_tdata !== 8'(i)) begin err_cnt++; $display("FAIL rstpkt_beat %0d tdata got %0d want %0d", i, axis_if.axis_tdata, i); end
    end
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || axis_if.axis_tlast !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL abort tvalid=%b tlast=%b busy=%b want 0 0 0", axis_if.axis_tvalid, axis_if.axis_tlast, busy);
    end
    vec_cnt++; if (pkt_cnt !== exp_cnt) begin err_cnt++; $display("FAIL abort_cnt got %0d want 0", pkt_cnt); end
    enable = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    step(); step();
    vec_cnt++; if (axis_if.axis_tvalid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL post_rst tvalid=%b busy=%b want 0 0", axis_if.axis_tvalid, busy); end
  endtask

  task automatic test_wrap();
    pkt_len = 10'd0; enable = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    vec_cnt++; if (pkt_cnt !== 16'hFFFF || axis_if.axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL wrap_pre cnt=%0h tlast=%b want ffff 1", pkt_cnt, axis_if.axis_tlast); end
    enable = 1'b0;
    step();
    vec_cnt++; if (pkt_cnt !== 16'h0000 || busy !== 1'b0) begin err_cnt++; $display("FAIL wrap_post cnt=%0h busy=%b want 0 0", pkt_cnt, busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_single_beat();
    test_gap();
    test_enable_drop_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
